cond_stage: RTL

Conditional-execution stage that sits directly downstream of the ALU. It consumes the ALU's 4-bit NZCV flag vector and the decoder's predicate and write-intent controls, and holds the architectural NZCV register. It evaluates the instruction's 4-bit ARM condition code and registers the gated PCSrc/RegWrite/MemWrite strobes into a one-entry valid/ready pipeline slot feeding writeback. It also keeps saturating executed/squashed counters for debug.

---
 rtl/cond_stage_pkg.sv | 36 +++
 rtl/cond_stage_cond_check.sv | 47 ++++
 rtl/cond_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/cond_stage_pkg.sv
// Shared definitions for the conditional-execution stage.
// Condition-code encodings, NZCV bit positions and FlagW bit positions.
// No logic lives here; only constants used by cond_check and cond_stage.
`timescale 1ns/1ps
package cond_stage_pkg;

    // ARM condition-code encodings (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    // 1111 is executed unconditionally, same as AL
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside FlagW
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_stage_cond_check.sv
// Condition-code evaluator: Cond and current NZCV in, pass out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it has no handshake of its own.
`timescale 1ns/1ps
module cond_check
    import cond_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field against the architectural flags
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_stage.sv
// Conditional-execution stage: holds NZCV, gates write strobes into a one-entry slot.
// Latency: 1 cycle from accept to out_valid/strobes and to the Flags port.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled slot holds flags and counters.
`timescale 1ns/1ps
module cond_stage
    import cond_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       accept;
    logic       pass;
    logic [3:0] flags_q;

    // Evaluation always sees the flags from before this edge, so an
    // instruction accepted right after a flag setter sees its result.
    cond_check u_cond_check (
        .cond  (Cond),
        .flags (flags_q),
        .pass  (pass)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign Flags    = flags_q;

    // Architectural NZCV: only an executed instruction may write it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (accept && pass) begin
            if (FlagW[FLAGW_NZ]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FLAGW_CV]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Slot valid: load on accept, drain when downstream takes it without a refill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Slot payload: gated strobes captured on accept, held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CondEx   <= 1'b0;
            PCSrc    <= 1'b0;
            RegWrite <= 1'b0;
            MemWrite <= 1'b0;
        end else if (accept) begin
            CondEx   <= pass;
            PCSrc    <= PCS & pass;
            RegWrite <= RegW & pass & ~NoWrite;
            MemWrite <= MemW & pass;
        end
    end

    // Debug counters: one of the two advances per accept, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_cnt   <= '0;
            squash_cnt <= '0;
        end else if (accept) begin
            if (pass) begin
                if (exec_cnt != CNT_MAX) begin
                    exec_cnt <= exec_cnt + 1'b1;
                end
            end else begin
                if (squash_cnt != CNT_MAX) begin
                    squash_cnt <= squash_cnt + 1'b1;
                end
            end
        end
    end

endmodule
